// File: rtl/ysyx_25040111_rd_arbiter.sv
// Two-master round-robin arbiter for the AR/R read channel.
// One outstanding transaction; the address is held to the slave until R completes.
module ysyx_25040111_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic grant0, grant1;
    logic in_idle, in_resp;

    assign in_idle = (state_q == IDLE);
    assign in_resp = (state_q == RESP);

    // On a tie the master that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (m0_arvalid && m1_arvalid) begin
            grant0 = last_q;
            grant1 = ~last_q;
        end else begin
            grant0 = m0_arvalid;
            grant1 = m1_arvalid;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;

        unique case (state_q)
            IDLE: begin
                m0_arready = grant0;
                m1_arready = grant1;
                if (grant0) begin
                    addr_d  = m0_araddr;
                    owner_d = 1'b0;
                    state_d = ADDR;
                end else if (grant1) begin
                    addr_d  = m1_araddr;
                    owner_d = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                s_araddr  = addr_q;
                if (s_arready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Slave may still sample the address after its AR handshake.
                s_araddr = addr_q;
                if (owner_q) begin
                    s_rready  = m1_rready;
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    s_rready  = m0_rready;
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                if (s_rvalid && s_rready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    logic unused_idle;
    assign unused_idle = in_idle & in_resp;

endmodule

// File: tb/tb_ysyx_25040111_rd_arbiter.sv
// Directed table-driven bench for the two-master read arbiter.
// Each record is one cycle: inputs applied, combinational outputs checked.
module tb_ysyx_25040111_rd_arbiter;

    localparam logic [31:0] A0 = 32'ha000_0048;
    localparam logic [31:0] A1 = 32'ha000_004c;
    localparam logic [31:0] D  = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_25040111_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
        .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready)
    );

    // in : {rst, m0v, m0rr, m1v, m1rr, s_arready, s_rvalid}
    // exp: {m0_arready, m1_arready, s_arvalid, s_rready}
    // own: 0 = no R pass-through, 1 = m0 owns R, 2 = m1 owns R
    typedef struct {
        logic [6:0]  in;
        logic [1:0]  resp;
        logic [3:0]  exp;
        logic [31:0] sara;
        logic [1:0]  own;
    } vec_t;

    function automatic vec_t mk(logic [6:0] in, logic [1:0] resp,
                                logic [3:0] exp, logic [31:0] sara,
                                logic [1:0] own);
        vec_t v;
        v.in   = in;
        v.resp = resp;
        v.exp  = exp;
        v.sara = sara;
        v.own  = own;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [111:0] act, req;
        logic         srv;
        @(negedge clk);
        {rst, m0_arvalid, m0_rready, m1_arvalid, m1_rready,
         s_arready, s_rvalid} = v.in;
        s_rresp = v.resp;
        srv     = v.in[0];
        #1;
        act = {m0_arready, m1_arready, s_arvalid, s_rready, s_araddr,
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_rresp, m1_rresp};
        req = {v.exp, v.sara,
               (v.own == 2'd1) & srv, (v.own == 2'd2) & srv,
               (v.own == 2'd1) ? D : 32'h0, (v.own == 2'd2) ? D : 32'h0,
               (v.own == 2'd1) ? v.resp : 2'b00,
               (v.own == 2'd2) ? v.resp : 2'b00};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", tag, idx, act, req);
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        m0_araddr = A0; m1_araddr = A1;
        m0_arvalid = 0; m1_arvalid = 0;
        m0_rready = 0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0;
        s_rdata = D; s_rresp = 2'b00;
        repeat (2) @(posedge clk);

        // m0 alone, zero-wait slave
        tbl.push_back(mk(7'b0000000, 2'd0, 4'b0000, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0100010, 2'd0, 4'b1000, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0000010, 2'd0, 4'b0010, A0,    2'd0));
        tbl.push_back(mk(7'b0010001, 2'd0, 4'b0001, A0,    2'd1));
        tbl.push_back(mk(7'b0000000, 2'd0, 4'b0000, 32'h0, 2'd0));
        // reset, then tie: m0 first, m1 right after
        tbl.push_back(mk(7'b1000000, 2'd0, 4'b0000, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0101000, 2'd0, 4'b1000, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0001010, 2'd0, 4'b0010, A0,    2'd0));
        tbl.push_back(mk(7'b0011001, 2'd2, 4'b0001, A0,    2'd1));
        tbl.push_back(mk(7'b0001000, 2'd0, 4'b0100, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0000010, 2'd0, 4'b0010, A1,    2'd0));
        tbl.push_back(mk(7'b0010001, 2'd3, 4'b0000, A1,    2'd2));
        tbl.push_back(mk(7'b0000101, 2'd1, 4'b0001, A1,    2'd2));
        // reset while m1 owns RESP
        tbl.push_back(mk(7'b0001000, 2'd0, 4'b0100, 32'h0, 2'd0));
        tbl.push_back(mk(7'b0000010, 2'd0, 4'b0010, A1,    2'd0));
        tbl.push_back(mk(7'b1000100, 2'd0, 4'b0001, A1,    2'd2));
        tbl.push_back(mk(7'b0000101, 2'd0, 4'b0000, 32'h0, 2'd0));
        // m1 alone three times back to back
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(7'b0001000, 2'd0, 4'b0100, 32'h0, 2'd0));
            tbl.push_back(mk(7'b0001010, 2'd0, 4'b0010, A1,    2'd0));
            tbl.push_back(mk(7'b0001101, 2'd0, 4'b0001, A1,    2'd2));
        end
        tbl.push_back(mk(7'b0000000, 2'd0, 4'b0000, 32'h0, 2'd0));

        foreach (tbl[i]) apply(tbl[i], "table", i);

        // both masters always requesting: grants alternate m0,m1,...
        apply(mk(7'b1000000, 2'd0, 4'b0000, 32'h0, 2'd0), "rr_rst", 0);
        for (int k = 0; k < 6; k++) begin
            apply(mk(7'b0111111, 2'd0, (k % 2 == 0) ? 4'b1000 : 4'b0100,
                     32'h0, 2'd0), "rr_grant", k);
            apply(mk(7'b0111111, 2'd0, 4'b0010,
                     (k % 2 == 0) ? A0 : A1, 2'd0), "rr_addr", k);
            apply(mk(7'b0111111, 2'd0, 4'b0001,
                     (k % 2 == 0) ? A0 : A1,
                     (k % 2 == 0) ? 2'd1 : 2'd2), "rr_resp", k);
        end

        // slow slave: AR stalls 5 cycles, owner withholds rready 3 cycles
        apply(mk(7'b1000000, 2'd0, 4'b0000, 32'h0, 2'd0), "st_rst", 0);
        apply(mk(7'b0101000, 2'd0, 4'b1000, 32'h0, 2'd0), "st_grant", 0);
        for (int k = 0; k < 5; k++)
            apply(mk(7'b0001000, 2'd0, 4'b0010, A0, 2'd0), "st_arwait", k);
        apply(mk(7'b0001010, 2'd0, 4'b0010, A0, 2'd0), "st_arhs", 0);
        for (int k = 0; k < 3; k++)
            apply(mk(7'b0001001, 2'd1, 4'b0000, A0, 2'd1), "st_rwait", k);
        apply(mk(7'b0011001, 2'd1, 4'b0001, A0, 2'd1), "st_rhs", 0);
        apply(mk(7'b0001000, 2'd0, 4'b0100, 32'h0, 2'd0), "st_next", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
